// File: rtl/c499_sec_pkg.sv
// Shared definitions for the c499 SEC encoder and its corrector bench:
// widths, codeword layout, check equations and fault-mask helper.
package c499_sec_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CHK_W  = 8;
    localparam int unsigned CW_W   = 40;
    localparam int unsigned NIB_N  = 8;
    localparam int unsigned BIT_W  = 6;

    typedef struct packed {
        logic [CHK_W-1:0]  chk;
        logic [DATA_W-1:0] data;
    } codeword_t;

    // Flat form of the eight check equations
    function automatic logic [CHK_W-1:0] sec_check(input logic [DATA_W-1:0] d);
        logic [CHK_W-1:0] c;
        c[0] = ^{d[0], d[4], d[8],  d[12], d[23:16]};
        c[1] = ^{d[1], d[5], d[9],  d[13], d[31:24]};
        c[2] = ^{d[2], d[6], d[10], d[14], d[19:16], d[27:24]};
        c[3] = ^{d[3], d[7], d[11], d[15], d[23:20], d[31:28]};
        c[4] = ^{d[16], d[20], d[24], d[28], d[7:0]};
        c[5] = ^{d[17], d[21], d[25], d[29], d[15:8]};
        c[6] = ^{d[18], d[22], d[26], d[30], d[3:0], d[11:8]};
        c[7] = ^{d[19], d[23], d[27], d[31], d[7:4], d[15:12]};
        return c;
    endfunction

    // Same equations with the byte-group terms folded into nibble parities
    function automatic logic [CHK_W-1:0] sec_combine(input logic [DATA_W-1:0] d,
                                                     input logic [NIB_N-1:0]  n);
        logic [CHK_W-1:0] c;
        c[0] = d[0]  ^ d[4]  ^ d[8]  ^ d[12] ^ n[4] ^ n[5];
        c[1] = d[1]  ^ d[5]  ^ d[9]  ^ d[13] ^ n[6] ^ n[7];
        c[2] = d[2]  ^ d[6]  ^ d[10] ^ d[14] ^ n[4] ^ n[6];
        c[3] = d[3]  ^ d[7]  ^ d[11] ^ d[15] ^ n[5] ^ n[7];
        c[4] = d[16] ^ d[20] ^ d[24] ^ d[28] ^ n[0] ^ n[1];
        c[5] = d[17] ^ d[21] ^ d[25] ^ d[29] ^ n[2] ^ n[3];
        c[6] = d[18] ^ d[22] ^ d[26] ^ d[30] ^ n[0] ^ n[2];
        c[7] = d[19] ^ d[23] ^ d[27] ^ d[31] ^ n[1] ^ n[3];
        return c;
    endfunction

    // One-hot flip over the codeword; indices past the codeword give no flip
    function automatic codeword_t flip_mask(input logic [BIT_W-1:0] bit_idx);
        logic [CW_W-1:0] m;
        m = '0;
        if (bit_idx < BIT_W'(CW_W)) m = CW_W'(1) << bit_idx;
        return codeword_t'(m);
    endfunction

endpackage

// File: rtl/c499_sec_encoder_if.sv
// Stream, injector and status signals of the c499 SEC encoder.
interface c499_sec_encoder_if #(
    parameter int unsigned CNT_W = 16
);
    import c499_sec_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              inj_arm;
    logic [BIT_W-1:0]  inj_bit;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CHK_W-1:0]  out_chk;
    logic              inj_busy;
    logic [CNT_W-1:0]  word_cnt;

    modport master (
        output in_valid, in_data, inj_arm, inj_bit, out_ready,
        input  in_ready, out_valid, out_data, out_chk, inj_busy, word_cnt
    );

    modport slave (
        input  in_valid, in_data, inj_arm, inj_bit, out_ready,
        output in_ready, out_valid, out_data, out_chk, inj_busy, word_cnt
    );
endinterface

// File: rtl/c499_nib_par.sv
// Stage-1 logic: XOR parity of each 4-bit nibble of the data word.
module c499_nib_par
    import c499_sec_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [NIB_N-1:0]  nib
);

    always_comb begin
        nib = '0;
        for (int i = 0; i < int'(NIB_N); i++) begin
            nib[i] = ^data[4*i +: 4];
        end
    end

endmodule

// File: rtl/c499_sec_encoder.sv
// Streaming SEC encoder: 32-bit data -> {8 check, 32 data} codeword with a
// one-shot single-bit fault injector applied at the output register.
module c499_sec_encoder
    import c499_sec_pkg::*;
#(
    parameter int unsigned PIPE_STAGES = 2,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst,
    c499_sec_encoder_if.slave   bus
);

    logic              in_ready_c;
    logic              in_fire;
    logic              out_adv;
    logic              inj_busy_q;
    logic [CNT_W-1:0]  cnt_q;
    codeword_t         in_mask;

    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic [CHK_W-1:0]  src_chk;
    codeword_t         src_mask;

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [CHK_W-1:0]  out_chk_q;

    assign in_fire = bus.in_valid && in_ready_c;
    assign out_adv = !out_valid_q || bus.out_ready;
    assign in_mask = (in_fire && inj_busy_q) ? flip_mask(bus.inj_bit) : '0;

    // Arm has priority so a coinciding arm re-arms for the following word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inj_busy_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            if (in_fire)          cnt_q      <= cnt_q + CNT_W'(1);
            if (bus.inj_arm)      inj_busy_q <= 1'b1;
            else if (in_fire)     inj_busy_q <= 1'b0;
        end
    end

    if (PIPE_STAGES == 1) begin : g_one_stage
        assign in_ready_c = out_adv;
        assign src_valid  = bus.in_valid;
        assign src_data   = bus.in_data;
        assign src_chk    = sec_check(bus.in_data);
        assign src_mask   = in_mask;
    end else begin : g_two_stage
        logic              s1_valid_q;
        logic [DATA_W-1:0] s1_data_q;
        logic [NIB_N-1:0]  s1_nib_q;
        codeword_t         s1_mask_q;
        logic [NIB_N-1:0]  nib;

        c499_nib_par u_nib_par (
            .data (bus.in_data),
            .nib  (nib)
        );

        assign in_ready_c = !s1_valid_q || (s1_valid_q && out_adv);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_valid_q <= 1'b0;
                s1_data_q  <= '0;
                s1_nib_q   <= '0;
                s1_mask_q  <= '0;
            end else if (in_ready_c) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_data_q <= bus.in_data;
                    s1_nib_q  <= nib;
                    s1_mask_q <= in_mask;
                end
            end
        end

        assign src_valid = s1_valid_q;
        assign src_data  = s1_data_q;
        assign src_chk   = sec_combine(s1_data_q, s1_nib_q);
        assign src_mask  = s1_mask_q;
    end

    // Output register; check bits come from clean data, flip applied here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chk_q   <= '0;
        end else if (out_adv) begin
            out_valid_q <= src_valid;
            if (src_valid) begin
                out_data_q <= src_data ^ src_mask.data;
                out_chk_q  <= src_chk  ^ src_mask.chk;
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_chk   = out_chk_q;
    assign bus.inj_busy  = inj_busy_q;
    assign bus.word_cnt  = cnt_q;

endmodule

// File: tb/tb_c499_sec_encoder.sv
// Self-checking bench for c499_sec_encoder: directed steps plus random
// traffic scored against a mask-table check model and a c499 corrector model.
module tb_c499_sec_encoder;
    import c499_sec_pkg::*;

    localparam logic [31:0] CHK_MASK [0:7] = '{
        32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
        32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
    };
    localparam logic [31:0] DIR_D [0:3] = '{32'h00000000, 32'h00000001, 32'h80000000, 32'hFFFFFFFF};
    localparam logic [7:0]  DIR_C [0:3] = '{8'h00, 8'h51, 8'h8A, 8'h00};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    c499_sec_encoder_if #(.CNT_W(16)) bus ();

    c499_sec_encoder #(.PIPE_STAGES(2), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [39:0] exp_q[$];
    logic [39:0] got_q[$];
    bit          mdl_busy = 1'b0;
    int unsigned mdl_cnt  = 0;
    int          out_cycles = 0;

    function automatic logic [7:0] ref_chk(input logic [31:0] d);
        logic [7:0] r;
        for (int k = 0; k < 8; k++) r[k] = ^(d & CHK_MASK[k]);
        return r;
    endfunction

    // c499 with N137=1: flip the data bit whose column equals the syndrome
    function automatic logic [31:0] c499_ref(input logic [31:0] d, input logic [7:0] c);
        logic [7:0]  syn;
        logic [7:0]  col;
        logic [31:0] r;
        syn = c ^ ref_chk(d);
        r   = d;
        for (int i = 0; i < 32; i++) begin
            for (int k = 0; k < 8; k++) col[k] = CHK_MASK[k][i];
            if (syn == col) r[i] = ~r[i];
        end
        return r;
    endfunction

    // Reference model and output collector, sampled mid-cycle
    always @(negedge clk) begin
        logic [39:0] m;
        if (rst) begin
            mdl_busy = 1'b0;
            mdl_cnt  = 0;
        end else begin
            if (bus.out_valid) out_cycles++;
            if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_chk, bus.out_data});
            if (bus.in_valid && bus.in_ready) begin
                m = mdl_busy ? (40'(1) << bus.inj_bit) : 40'(0);
                exp_q.push_back({ref_chk(bus.in_data), bus.in_data} ^ m);
                mdl_cnt++;
                mdl_busy = 1'b0;
            end
            if (bus.inj_arm) mdl_busy = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drain_compare(input string tag, input bit clean);
        chk({tag, " count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) begin
                chk({tag, " word"}, 64'(got_q[i]), 64'(exp_q[i]));
                if (clean)
                    chk({tag, " c499"}, 64'(c499_ref(got_q[i][31:0], got_q[i][39:32])),
                        64'(exp_q[i][31:0]));
            end
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send_word(input logic [31:0] d, input logic [5:0] b, input logic arm);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.inj_bit  = b;
        bus.inj_arm  = arm;
        tick();
        bus.in_valid = 1'b0;
        bus.inj_arm  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int          stalls;
        int          sent;
        int          guard;
        bit          fired;
        logic [15:0] cnt0;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.inj_arm   = 1'b0;
        bus.inj_bit   = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        chk("rst out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst out_data",  64'(bus.out_data),  64'(0));
        chk("rst out_chk",   64'(bus.out_chk),   64'(0));
        chk("rst inj_busy",  64'(bus.inj_busy),  64'(0));
        chk("rst word_cnt",  64'(bus.word_cnt),  64'(0));
        rst = 1'b0;
        tick();

        // Known check vectors and two-cycle latency
        for (int i = 0; i < 4; i++) begin
            send_word(DIR_D[i], 6'd0, 1'b0);
            chk("dir lat1 out_valid", 64'(bus.out_valid), 64'(0));
            tick();
            chk("dir lat2 out_valid", 64'(bus.out_valid), 64'(1));
            chk("dir out_chk",  64'(bus.out_chk),  64'(DIR_C[i]));
            chk("dir out_data", 64'(bus.out_data), 64'(DIR_D[i]));
        end
        tick();
        drain_compare("dir", 1'b1);

        // 100 back-to-back words
        cnt0 = bus.word_cnt;
        stalls = 0;
        out_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = $urandom;
            #1;
            if (!bus.in_ready) stalls++;
            tick();
        end
        chk("b2b valid cycles in loop", 64'(out_cycles), 64'(98));
        bus.in_valid = 1'b0;
        tick(); tick(); tick();
        chk("b2b stalls",       64'(stalls),       64'(0));
        chk("b2b valid cycles", 64'(out_cycles),   64'(100));
        chk("b2b word_cnt",     64'(bus.word_cnt), 64'(16'(cnt0 + 16'd100)));
        drain_compare("b2b", 1'b1);

        // Backpressure with a full pipe
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = $urandom;
        sent = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            fired = bus.in_ready;
            tick();
            if (fired) begin sent++; bus.in_data = $urandom; end
        end
        chk("stall fill count", 64'(sent), 64'(2));
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall in_ready",  64'(bus.in_ready),  64'(0));
            chk("stall out_valid", 64'(bus.out_valid), 64'(1));
            chk("stall held word", 64'({bus.out_chk, bus.out_data}), 64'(exp_q[0]));
            tick();
        end
        bus.out_ready = 1'b1;
        guard = 0;
        while (sent < 12 && guard < 40) begin
            #1;
            fired = bus.in_ready;
            tick();
            guard++;
            if (fired) begin sent++; bus.in_data = $urandom; end
        end
        chk("stall release sent", 64'(sent), 64'(12));
        bus.in_valid = 1'b0;
        tick(); tick(); tick(); tick();
        drain_compare("stall", 1'b1);
        chk("stall word_cnt", 64'(bus.word_cnt), 64'(16'(mdl_cnt)));

        // Fault injection, data bit 5
        bus.inj_arm = 1'b1;
        tick();
        bus.inj_arm = 1'b0;
        chk("inj armed", 64'(bus.inj_busy), 64'(1));
        send_word(32'h12345678, 6'd5, 1'b0);
        chk("inj consumed", 64'(bus.inj_busy), 64'(0));
        tick();
        chk("inj out_valid", 64'(bus.out_valid), 64'(1));
        chk("inj out_data",  64'(bus.out_data),  64'(32'h12345658));
        chk("inj out_chk",   64'(bus.out_chk),   64'(ref_chk(32'h12345678)));
        chk("inj c499 fix",  64'(c499_ref(bus.out_data, bus.out_chk)), 64'(32'h12345678));

        // Check-bit flip, out-of-range index, coinciding arm
        bus.inj_arm = 1'b1; tick(); bus.inj_arm = 1'b0;
        send_word(32'hA5A5A5A5, 6'd39, 1'b0);
        bus.inj_arm = 1'b1; tick(); bus.inj_arm = 1'b0;
        send_word(32'h0F0F00FF, 6'd45, 1'b0);
        chk("inj bit45 clears", 64'(bus.inj_busy), 64'(0));
        bus.inj_arm = 1'b1; tick(); bus.inj_arm = 1'b0;
        send_word(32'hDEADBEEF, 6'd0, 1'b1);
        chk("inj coincide stays", 64'(bus.inj_busy), 64'(1));
        send_word(32'hCAFEF00D, 6'd31, 1'b0);
        chk("inj coincide clears", 64'(bus.inj_busy), 64'(0));
        tick(); tick(); tick();
        drain_compare("inj", 1'b0);

        // Random traffic, backpressure and injections
        for (int i = 0; i < 60; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = $urandom;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            bus.inj_arm   = ($urandom_range(0, 4) == 0);
            bus.inj_bit   = 6'($urandom_range(0, 63));
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.inj_arm   = 1'b0;
        bus.out_ready = 1'b1;
        tick(); tick(); tick(); tick();
        drain_compare("rand", 1'b0);
        chk("rand word_cnt", 64'(bus.word_cnt), 64'(16'(mdl_cnt)));
        chk("rand inj_busy", 64'(bus.inj_busy), 64'(mdl_busy));

        // Reset with two words in flight and a fault armed
        bus.out_ready = 1'b0;
        send_word(32'h11112222, 6'd3, 1'b0);
        send_word(32'h33334444, 6'd3, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid rst out_valid", 64'(bus.out_valid), 64'(0));
        chk("mid rst word_cnt",  64'(bus.word_cnt),  64'(0));
        chk("mid rst inj_busy",  64'(bus.inj_busy),  64'(0));
        tick();
        rst = 1'b0;
        exp_q.delete();
        got_q.delete();
        bus.out_ready = 1'b1;
        out_cycles = 0;
        tick(); tick(); tick();
        chk("post rst no output", 64'(out_cycles), 64'(0));
        send_word(32'h55AA33CC, 6'd7, 1'b0);
        tick(); tick();
        drain_compare("post rst", 1'b1);
        chk("post rst word_cnt", 64'(bus.word_cnt), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
